// File: rtl/fir_load_controller_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fir_load_controller_if                                                   |
// | Handshake and filter-side bus of the FIR load sequencer.                 |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
interface fir_load_controller_if #(
    parameter int DATA_WIDTH  = 8,
    parameter int COEFF_WIDTH = 8
);
    logic                          start;
    logic                          abort;
    logic                          coeffValid;
    logic signed [COEFF_WIDTH-1:0] coeffIn;
    logic                          coeffReady;
    logic                          sampleValid;
    logic signed [DATA_WIDTH-1:0]  sampleIn;
    logic                          sampleLast;
    logic                          sampleReady;
    logic                          firCoeffSetFlag;
    logic signed [COEFF_WIDTH-1:0] firCoeffOut;
    logic                          firLoadDataFlag;
    logic signed [DATA_WIDTH-1:0]  firDataOut;
    logic                          firStopDataLoadFlag;
    logic                          firOutValid;
    logic                          busy;
    logic                          done;

    modport slave (
        input  start, abort, coeffValid, coeffIn, sampleValid, sampleIn, sampleLast,
        output coeffReady, sampleReady, firCoeffSetFlag, firCoeffOut, firLoadDataFlag,
               firDataOut, firStopDataLoadFlag, firOutValid, busy, done
    );

    modport master (
        output start, abort, coeffValid, coeffIn, sampleValid, sampleIn, sampleLast,
        input  coeffReady, sampleReady, firCoeffSetFlag, firCoeffOut, firLoadDataFlag,
               firDataOut, firStopDataLoadFlag, firOutValid, busy, done
    );
endinterface
`default_nettype wire

// File: rtl/fir_load_controller.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fir_load_controller                                                      |
// | Loads filter coefficients, streams samples, appends zero pads, stops.    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module fir_load_controller #(
    parameter int LENGTH      = 20,
    parameter int DATA_WIDTH  = 8,
    parameter int COEFF_WIDTH = 8,
    parameter int FIR_LATENCY = 1
) (
    input  wire logic             clock,
    input  wire logic             resetN,
    fir_load_controller_if.slave  bus
);
    localparam int                   c_count_w  = $clog2(LENGTH + 1);
    localparam logic [c_count_w-1:0] c_last_idx = c_count_w'(LENGTH - 1);
    localparam logic [c_count_w-1:0] c_one      = c_count_w'(1);

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_LOAD_COEFF = 3'd1,
        ST_LOAD_DATA  = 3'd2,
        ST_FLUSH      = 3'd3,
        ST_FINISH     = 3'd4
    } state_e;

    state_e                        state_q, state_d;
    logic [c_count_w-1:0]          coeff_count_q, coeff_count_d;
    logic [c_count_w-1:0]          pad_count_q, pad_count_d;
    logic                          coeff_set_q, coeff_set_d;
    logic signed [COEFF_WIDTH-1:0] coeff_out_q, coeff_out_d;
    logic                          load_q, load_d;
    logic signed [DATA_WIDTH-1:0]  data_out_q, data_out_d;
    logic                          stop_q, stop_d;
    logic                          done_q, done_d;
    logic [FIR_LATENCY-1:0]        valid_pipe_q, valid_pipe_d;

    logic w_coeff_accept;
    logic w_sample_accept;

    assign w_coeff_accept  = bus.coeffValid  & (state_q == ST_LOAD_COEFF);
    assign w_sample_accept = bus.sampleValid & (state_q == ST_LOAD_DATA);

    always_comb begin
        state_d       = state_q;
        coeff_count_d = coeff_count_q;
        pad_count_d   = pad_count_q;
        coeff_set_d   = 1'b0;
        coeff_out_d   = coeff_out_q;
        load_d        = 1'b0;
        data_out_d    = data_out_q;
        stop_d        = 1'b0;
        done_d        = 1'b0;
        valid_pipe_d  = '0;

        valid_pipe_d[0] = load_q;
        for (int i = 1; i < FIR_LATENCY; i++) begin
            valid_pipe_d[i] = valid_pipe_q[i-1];
        end

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d       = ST_LOAD_COEFF;
                    coeff_count_d = '0;
                end
            end
            ST_LOAD_COEFF: begin
                if (w_coeff_accept) begin
                    coeff_set_d = 1'b1;
                    coeff_out_d = bus.coeffIn;
                    if (coeff_count_q == c_last_idx) begin
                        state_d       = ST_LOAD_DATA;
                        coeff_count_d = '0;
                    end else begin
                        coeff_count_d = coeff_count_q + c_one;
                    end
                end
            end
            ST_LOAD_DATA: begin
                if (w_sample_accept) begin
                    load_d     = 1'b1;
                    data_out_d = bus.sampleIn;
                    if (bus.sampleLast) begin
                        // A single-tap filter needs no padding at all.
                        if (LENGTH > 1) begin
                            state_d     = ST_FLUSH;
                            pad_count_d = c_last_idx;
                        end else begin
                            state_d = ST_FINISH;
                        end
                    end
                end
            end
            ST_FLUSH: begin
                load_d      = 1'b1;
                data_out_d  = '0;
                pad_count_d = pad_count_q - c_one;
                if (pad_count_q == c_one) begin
                    state_d = ST_FINISH;
                end
            end
            ST_FINISH: begin
                stop_d  = 1'b1;
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Abort wins over everything; it only emits a stop when a run was live.
        if (bus.abort) begin
            state_d       = ST_IDLE;
            coeff_count_d = '0;
            pad_count_d   = '0;
            coeff_set_d   = 1'b0;
            coeff_out_d   = coeff_out_q;
            load_d        = 1'b0;
            data_out_d    = data_out_q;
            done_d        = 1'b0;
            stop_d        = (state_q != ST_IDLE);
            valid_pipe_d  = '0;
        end
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state_q       <= ST_IDLE;
            coeff_count_q <= '0;
            pad_count_q   <= '0;
            coeff_set_q   <= 1'b0;
            coeff_out_q   <= '0;
            load_q        <= 1'b0;
            data_out_q    <= '0;
            stop_q        <= 1'b0;
            done_q        <= 1'b0;
            valid_pipe_q  <= '0;
        end else begin
            state_q       <= state_d;
            coeff_count_q <= coeff_count_d;
            pad_count_q   <= pad_count_d;
            coeff_set_q   <= coeff_set_d;
            coeff_out_q   <= coeff_out_d;
            load_q        <= load_d;
            data_out_q    <= data_out_d;
            stop_q        <= stop_d;
            done_q        <= done_d;
            valid_pipe_q  <= valid_pipe_d;
        end
    end

    assign bus.coeffReady          = (state_q == ST_LOAD_COEFF);
    assign bus.sampleReady         = (state_q == ST_LOAD_DATA);
    assign bus.busy                = (state_q != ST_IDLE);
    assign bus.firCoeffSetFlag     = coeff_set_q;
    assign bus.firCoeffOut         = coeff_out_q;
    assign bus.firLoadDataFlag     = load_q;
    assign bus.firDataOut          = data_out_q;
    assign bus.firStopDataLoadFlag = stop_q;
    assign bus.done                = done_q;
    assign bus.firOutValid         = valid_pipe_q[FIR_LATENCY-1];

endmodule
`default_nettype wire
